mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 37 +++
 rtl/mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// State encoding, access sizes and the IO window match live here.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] IO_SEL = 2'b11;

  // Size 3 is illegal and behaves as a word.
  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic is_io(
    input logic [31:0] a
  );
    return a[17:16] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto a byte-wide RAM port.
// Reads return one cycle after the address; stores to IO honour backpressure.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [2:0]  r_k;
  logic [2:0]  r_n;
  logic [31:0] r_base;
  logic [31:0] r_wdata;
  logic [31:0] r_result;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;
  logic        r_is_ls;
  logic        r_last_ls;
  logic        r_io;

  logic        w_if_ok;
  logic        w_ls_ok;
  logic        w_grant_ls;
  logic        w_grant_if;
  logic        w_stall;
  logic [2:0]  w_idx;
  logic [1:0]  w_bi;
  logic [31:0] w_addr;
  logic [31:0] w_res_nxt;

  always_comb begin
    w_if_ok    = if_req & ~flush;
    w_ls_ok    = ls_req & (~flush | ls_wr);
    w_grant_ls = w_ls_ok & (~w_if_ok | ~r_last_ls);
    w_grant_if = w_if_ok & ~w_grant_ls;
    w_stall    = r_io & io_buffer_full;
    // While frozen, keep presenting the byte still owed to the capture.
    w_idx = r_k;
    if (!rdy && r_state == S_READ && r_k != 3'd0)
      w_idx = r_k - 3'd1;
    w_addr    = r_base + {29'd0, w_idx};
    w_bi      = r_k[1:0] - 2'd1;
    w_res_nxt = r_result;
    if (r_k != 3'd0)
      w_res_nxt[{w_bi, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_ls)
          w_state_nxt = ls_wr ? S_WRITE : S_READ;
        else if (w_grant_if)
          w_state_nxt = S_READ;
      end
      S_READ: begin
        if (flush)
          w_state_nxt = S_IDLE;
        else if (r_k == r_n)
          w_state_nxt = S_DONE;
      end
      S_WRITE: begin
        if (!w_stall && r_k == r_n - 3'd1)
          w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    if (r_state == S_READ || r_state == S_WRITE)
      mem_a = w_addr;
    if (r_state == S_WRITE) begin
      mem_dout = r_wdata[{r_k[1:0], 3'b000} +: 8];
      mem_wr   = rdy & ~w_stall;
    end
    if_done  = (r_state == S_DONE) & rdy & ~r_is_ls;
    ls_done  = (r_state == S_DONE) & rdy & r_is_ls;
    if_data  = r_if_data;
    ls_rdata = r_ls_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_k        <= 3'd0;
      r_n        <= 3'd0;
      r_base     <= 32'd0;
      r_wdata    <= 32'd0;
      r_result   <= 32'd0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
      r_is_ls    <= 1'b0;
      r_last_ls  <= 1'b1;
      r_io       <= 1'b0;
    end else if (rdy) begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_ls || w_grant_if) begin
            r_k       <= 3'd0;
            r_result  <= 32'd0;
            r_is_ls   <= w_grant_ls;
            r_last_ls <= w_grant_ls;
            r_wdata   <= ls_wdata;
            r_base    <= w_grant_ls ? ls_addr : if_addr;
            r_n       <= w_grant_ls ? size_bytes(ls_size) : 3'd4;
            r_io      <= w_grant_ls & ls_wr & is_io(ls_addr);
          end
        end
        S_READ: begin
          if (!flush) begin
            r_k      <= r_k + 3'd1;
            r_result <= w_res_nxt;
            if (r_k == r_n) begin
              if (r_is_ls)
                r_ls_rdata <= w_res_nxt;
              else
                r_if_data <= w_res_nxt;
            end
          end
        end
        S_WRITE: begin
          if (!w_stall)
            r_k <= r_k + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model.
// Each scenario logs per-cycle port activity and checks hand-derived values.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        ls_req;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .flush(flush),
    .if_req(if_req), .if_addr(if_addr),
    .if_data(if_data), .if_done(if_done),
    .ls_req(ls_req), .ls_wr(ls_wr),
    .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_done(ls_done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:4095];

  always @(posedge clk)
    mem_din <= ram[mem_a[11:0]];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] la  [0:31];
  logic        lwr [0:31];
  logic [7:0]  ldo [0:31];
  int          if_first, if_cnt, ls_first, ls_cnt, wr_cnt;
  logic [31:0] if_dat, ls_dat;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    io_buffer_full = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    if_addr = '0; ls_addr = '0;
    ls_size = '0; ls_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Cycle 0 is the cycle in which requests are presented.
  task automatic run(input int n, input int rlo, input int rhi,
                     input int iolo, input int iohi,
                     input int fcyc, input int ifoff);
    logic d_if, d_ls;
    if_cnt = 0; ls_cnt = 0; wr_cnt = 0;
    if_first = -1; ls_first = -1;
    for (int i = 0; i < n; i++) begin
      rdy = !(i >= rlo && i < rhi);
      io_buffer_full = (i >= iolo && i < iohi);
      flush = (i == fcyc);
      if (i == ifoff) if_req = 1'b0;
      @(negedge clk);
      la[i] = mem_a; lwr[i] = mem_wr; ldo[i] = mem_dout;
      if (mem_wr) wr_cnt++;
      d_if = if_done; d_ls = ls_done;
      if (d_if) begin
        if (if_cnt == 0) if_first = i;
        if_cnt++; if_dat = if_data;
      end
      if (d_ls) begin
        if (ls_cnt == 0) ls_first = i;
        ls_cnt++; ls_dat = ls_rdata;
      end
      @(posedge clk);
      #1;
      if (d_if) if_req = 1'b0;
      if (d_ls) ls_req = 1'b0;
    end
    rdy = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
    ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'hAB; ram[12'h201] = 8'h5C;
    ram[12'h400] = 8'h78; ram[12'h401] = 8'h56;
    ram[12'h402] = 8'h34; ram[12'h403] = 8'h12;

    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    io_buffer_full = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
    if_addr = '0; ls_addr = '0;
    ls_size = '0; ls_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Word fetch
    if_addr = 32'h100; if_req = 1'b1;
    run(10, 99, 99, 99, 99, 99, 99);
    check("f_a1", la[1], 32'h100);
    check("f_a4", la[4], 32'h103);
    check("f_done_cyc", if_first, 6);
    check("f_done_cnt", if_cnt, 1);
    check("f_data", if_dat, 32'h0000_0513);
    check("f_no_wr", wr_cnt, 0);
    check("f_done_a", la[6], 32'd0);

    // Simultaneous fetch and byte load from reset
    do_reset();
    if_addr = 32'h100; if_req = 1'b1;
    ls_addr = 32'h200; ls_size = 2'd0;
    ls_wr = 1'b0; ls_req = 1'b1;
    run(14, 99, 99, 99, 99, 99, 99);
    check("rr_if_cyc", if_first, 6);
    check("rr_ls_cyc", ls_first, 10);
    check("rr_ls_a", la[8], 32'h200);
    check("rr_ls_data", ls_dat, 32'h0000_00AB);
    check("rr_ls_cnt", ls_cnt, 1);
    check("rr_if_hold", if_data, 32'h0000_0513);

    // Half store
    ls_addr = 32'h300; ls_size = 2'd1; ls_wr = 1'b1;
    ls_wdata = 32'h1234_ABCD; ls_req = 1'b1;
    run(6, 99, 99, 99, 99, 99, 99);
    check("hs_wr1", {31'd0, lwr[1]}, 32'd1);
    check("hs_a1", la[1], 32'h300);
    check("hs_d1", {24'd0, ldo[1]}, 32'hCD);
    check("hs_a2", la[2], 32'h301);
    check("hs_d2", {24'd0, ldo[2]}, 32'hAB);
    check("hs_done", ls_first, 3);
    check("hs_wr_cnt", wr_cnt, 2);

    // IO store with backpressure in cycles 1..3
    ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wr = 1'b1;
    ls_wdata = 32'h0000_0041; ls_req = 1'b1;
    run(8, 99, 99, 1, 4, 99, 99);
    check("io_stall", {29'd0, lwr[1], lwr[2], lwr[3]}, 32'd0);
    check("io_wr4", {31'd0, lwr[4]}, 32'd1);
    check("io_a4", la[4], 32'h0003_0000);
    check("io_d4", {24'd0, ldo[4]}, 32'h41);
    check("io_wr_cnt", wr_cnt, 1);
    check("io_done", ls_first, 5);

    // Fetch aborted by flush in cycle 3
    if_addr = 32'h100; if_req = 1'b1;
    run(10, 99, 99, 99, 99, 3, 4);
    check("fl_a3", la[3], 32'h102);
    check("fl_idle_a4", la[4], 32'd0);
    check("fl_no_done", if_cnt, 0);
    check("fl_if_hold", if_data, 32'h0000_0513);
    ls_addr = 32'h201; ls_size = 2'd0; ls_wr = 1'b0; ls_req = 1'b1;
    run(6, 99, 99, 99, 99, 99, 99);
    check("fl_next_cyc", ls_first, 3);
    check("fl_next_data", ls_dat, 32'h0000_005C);

    // rdy low for two cycles mid word load
    ls_addr = 32'h400; ls_size = 2'd2; ls_wr = 1'b0; ls_req = 1'b1;
    run(12, 3, 5, 99, 99, 99, 99);
    check("rdy_stall_wr", {31'd0, lwr[3] | lwr[4]}, 32'd0);
    check("rdy_a5", la[5], 32'h402);
    check("rdy_done", ls_first, 8);
    check("rdy_data", ls_dat, 32'h1234_5678);

    // Flush in an idle cycle: fetch and load wait, store proceeds
    if_addr = 32'h100; if_req = 1'b1;
    run(10, 99, 99, 99, 99, 0, 99);
    check("fi_if_cyc", if_first, 7);
    ls_addr = 32'h200; ls_size = 2'd0; ls_wr = 1'b0; ls_req = 1'b1;
    run(6, 99, 99, 99, 99, 0, 99);
    check("fi_ld_cyc", ls_first, 4);
    ls_addr = 32'h500; ls_wdata = 32'h77; ls_wr = 1'b1; ls_req = 1'b1;
    run(4, 99, 99, 99, 99, 0, 99);
    check("fi_st_wr1", {31'd0, lwr[1]}, 32'd1);
    check("fi_st_d1", {24'd0, ldo[1]}, 32'h77);
    check("fi_st_cyc", ls_first, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
